// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a frame-synchronous test-pattern source.
// Every output is registered from the same hc/vc position, so one output cycle describes one pixel.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        active_draw,
  output logic        h_sync,
  output logic        v_sync,
  output logic        new_frame,
  output logic [5:0]  frame_count,
  output logic [23:0] pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON  = SYNC_POL;
  localparam logic        SYNC_OFF = ~SYNC_POL;

  localparam logic [1:0] PAT_SOLID   = 2'd0;
  localparam logic [1:0] PAT_BARS    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;

  logic [10:0] hc_reg;
  logic [9:0]  vc_reg;
  logic [1:0]  pattern_q;

  logic        active_next;
  logic        hs_next;
  logic        vs_next;
  logic        frame_tick;
  logic [7:0]  bar_ge;
  logic [2:0]  bar_idx;
  logic [23:0] bar_color;
  logic [23:0] pixel_next;

  assign active_next = (hc_reg < H_ACT) && (vc_reg < V_ACT);
  assign hs_next     = (hc_reg >= HS_START) && (hc_reg < HS_END);
  assign vs_next     = (vc_reg >= VS_START) && (vc_reg < VS_END);
  assign frame_tick  = (hc_reg == H_ACT) && (vc_reg == V_ACT);

  // Bar boundaries as a bank of constant comparators; no divider in the pixel path.
  assign bar_ge[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_cmp
      assign bar_ge[gi] = (hc_reg >= 11'(gi * BAR_W));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) bar_idx = 3'(i);
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  end

  always_comb begin
    pixel_next = 24'h000000;
    if (active_next) begin
      case (pattern_q)
        PAT_SOLID:   pixel_next = solid_color;
        PAT_BARS:    pixel_next = bar_color;
        PAT_CHECKER: pixel_next = (hc_reg[5] ^ vc_reg[5]) ? 24'hFFFFFF : 24'h000000;
        default:     pixel_next = {hc_reg[7:0], vc_reg[7:0], frame_count, 2'b00};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_reg      <= '0;
      vc_reg      <= '0;
      pattern_q   <= PAT_SOLID;
      frame_count <= '0;
      h_count     <= '0;
      v_count     <= '0;
      active_draw <= 1'b0;
      h_sync      <= SYNC_OFF;
      v_sync      <= SYNC_OFF;
      new_frame   <= 1'b0;
      pixel       <= '0;
    end else begin
      if (hc_reg == H_MAX) begin
        hc_reg <= '0;
        vc_reg <= (vc_reg == V_MAX) ? 10'd0 : vc_reg + 10'd1;
      end else begin
        hc_reg <= hc_reg + 11'd1;
      end

      // Pattern only changes during blanking, so a frame never mixes two patterns.
      if (frame_tick) begin
        frame_count <= frame_count + 6'd1;
        pattern_q   <= pattern_sel;
      end

      h_count     <= hc_reg;
      v_count     <= vc_reg;
      active_draw <= active_next;
      h_sync      <= hs_next ? SYNC_ON : SYNC_OFF;
      v_sync      <= vs_next ? SYNC_ON : SYNC_OFF;
      new_frame   <= frame_tick;
      pixel       <= pixel_next;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench: a 720p-wide instance with short frames, a small instance with active-low
// syncs, and a tiny instance for frame counter wrap and gradient.
module tb_video_timing_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Wide: 1280/110/40/220 horizontal, 2/1/1/1 vertical (8250 cycles per frame).
  logic        rst_f;
  logic [1:0]  sel_f;
  logic [23:0] solid_f;
  logic [10:0] h_f;
  logic [9:0]  v_f;
  logic        act_f, hs_f, vs_f, nf_f;
  logic [5:0]  fc_f;
  logic [23:0] pix_f;

  // Mid: 40/1/1/1 x 33/2/3/2 (43 x 40 = 1720 cycles per frame), active-low syncs.
  logic        rst_m;
  logic [1:0]  sel_m;
  logic [23:0] solid_m;
  logic [10:0] h_m;
  logic [9:0]  v_m;
  logic        act_m, hs_m, vs_m, nf_m;
  logic [5:0]  fc_m;
  logic [23:0] pix_m;

  // Tiny: 8/1/1/1 x 2/1/1/1 (11 x 5 = 55 cycles per frame).
  logic        rst_t;
  logic [1:0]  sel_t;
  logic [23:0] solid_t;
  logic [10:0] h_t;
  logic [9:0]  v_t;
  logic        act_t, hs_t, vs_t, nf_t;
  logic [5:0]  fc_t;
  logic [23:0] pix_t;

  video_timing_pattern_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_full (
    .clk(clk), .rst(rst_f), .pattern_sel(sel_f), .solid_color(solid_f),
    .h_count(h_f), .v_count(v_f), .active_draw(act_f), .h_sync(hs_f),
    .v_sync(vs_f), .new_frame(nf_f), .frame_count(fc_f), .pixel(pix_f)
  );

  video_timing_pattern_gen #(
    .H_ACTIVE(40), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(33), .V_FP(2), .V_SYNC(3), .V_BP(2), .SYNC_POL(1'b0)
  ) u_mid (
    .clk(clk), .rst(rst_m), .pattern_sel(sel_m), .solid_color(solid_m),
    .h_count(h_m), .v_count(v_m), .active_draw(act_m), .h_sync(hs_m),
    .v_sync(vs_m), .new_frame(nf_m), .frame_count(fc_m), .pixel(pix_m)
  );

  video_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u_tiny (
    .clk(clk), .rst(rst_t), .pattern_sel(sel_t), .solid_color(solid_t),
    .h_count(h_t), .v_count(v_t), .active_draw(act_t), .h_sync(hs_t),
    .v_sync(vs_t), .new_frame(nf_t), .frame_count(fc_t), .pixel(pix_t)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // After release, the outputs on the n-th falling edge show raster index n-1.
  task automatic goto(input int idx);
    int n;
    n = idx + 1 - cyc;
    repeat (n) @(negedge clk);
    if (n > 0) cyc = idx + 1;
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last;
    int vs_cnt, vs_first, vs_last;
    int nf_cnt, nf_h, nf_v;
    int wrap_seen, wrap_v, wrap_prev_h, prev_h;

    rst_f = 1'b1; rst_m = 1'b1; rst_t = 1'b1;
    sel_f = 2'd1; sel_m = 2'd1; sel_t = 2'd3;
    solid_f = 24'h123456; solid_m = 24'h5A5A5A; solid_t = 24'h000000;

    repeat (3) @(negedge clk);
    check("rst_h",      32'(h_f),   32'd0);
    check("rst_v",      32'(v_f),   32'd0);
    check("rst_active", 32'(act_f), 32'd0);
    check("rst_pixel",  32'(pix_f), 32'd0);
    check("rst_nf",     32'(nf_f),  32'd0);
    check("rst_fc",     32'(fc_f),  32'd0);
    check("rst_hs_hi",  32'(hs_f),  32'd0);
    check("rst_vs_hi",  32'(vs_f),  32'd0);
    check("rst_hs_lo",  32'(hs_m),  32'd1);
    check("rst_vs_lo",  32'(vs_m),  32'd1);

    rst_f = 1'b0; rst_m = 1'b0; rst_t = 1'b0;
    cyc = 0;

    goto(0);
    check("first_h",      32'(h_f),   32'd0);
    check("first_v",      32'(v_f),   32'd0);
    check("first_active", 32'(act_f), 32'd1);
    check("first_solid",  32'(pix_f), 32'h123456);
    goto(1);
    check("second_h",     32'(h_f),   32'd1);
    check("second_v",     32'(v_f),   32'd0);

    goto(30);
    check("tiny_nf1",     32'(nf_t),  32'd1);
    check("tiny_fc1",     32'(fc_t),  32'd1);

    goto(1279);
    check("h1279",        32'(h_f),   32'd1279);
    check("h1279_active", 32'(act_f), 32'd1);
    goto(1280);
    check("h1280",        32'(h_f),   32'd1280);
    check("h1280_active", 32'(act_f), 32'd0);
    check("h1280_pixel",  32'(pix_f), 32'd0);

    hs_cnt = 0; hs_first = -1; hs_last = -1;
    vs_cnt = 0; vs_first = -1; vs_last = -1;
    nf_cnt = 0; nf_h = -1; nf_v = -1;
    wrap_seen = 0; wrap_v = -1; wrap_prev_h = -1; prev_h = 1280;
    for (int idx = 1281; idx <= 1719; idx++) begin
      goto(idx);
      if (hs_f && v_f == 10'd0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(h_f);
        hs_last = int'(h_f);
      end
      if (h_f == 11'd0 && wrap_seen == 0) begin
        wrap_seen = 1;
        wrap_v = int'(v_f);
        wrap_prev_h = prev_h;
      end
      prev_h = int'(h_f);
      if (!vs_m) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(v_m);
        vs_last = int'(v_m);
      end
      if (nf_m) begin
        nf_cnt++;
        nf_h = int'(h_m);
        nf_v = int'(v_m);
      end
    end
    check("hsync_first",  hs_first,    1390);
    check("hsync_last",   hs_last,     1429);
    check("hsync_width",  hs_cnt,      40);
    check("line_wrap_h",  wrap_prev_h, 1649);
    check("line_wrap_v",  wrap_v,      1);
    check("vsync_first",  vs_first,    35);
    check("vsync_last",   vs_last,     37);
    check("vsync_cycles", vs_cnt,      129);
    check("mid_nf_count", nf_cnt,      1);
    check("mid_nf_h",     nf_h,        40);
    check("mid_nf_v",     nf_v,        33);

    goto(1760);
    solid_f = 24'hABCDEF;
    goto(1761);
    check("solid_live",   32'(pix_f), 32'hABCDEF);

    goto(2600);
    sel_m = 2'd2;
    goto(3015);
    check("bars_persist", 32'(pix_m), 32'hFFFF00);
    goto(3178);
    check("mid_nf_pre",   32'(nf_m),  32'd0);
    goto(3179);
    check("mid_nf_period", 32'(nf_m), 32'd1);
    goto(3440);
    check("checker_0_0",  32'(pix_m), 32'h000000);
    goto(3465);
    check("grad_0_0",     32'(pix_t), 32'h0000FC);
    goto(3472);
    check("checker_32_0", 32'(pix_m), 32'hFFFFFF);
    goto(3479);
    check("grad_3_1",     32'(pix_t), 32'h0301FC);
    goto(3494);
    check("fc_63",        32'(fc_t),  32'd63);
    goto(3495);
    check("fc_wrap_nf",   32'(nf_t),  32'd1);
    check("fc_wrap",      32'(fc_t),  32'd0);

    goto(4579);
    check("full_nf_pre",  32'(nf_f),  32'd0);
    check("full_fc_pre",  32'(fc_f),  32'd0);
    goto(4580);
    check("full_nf",      32'(nf_f),  32'd1);
    check("full_nf_h",    32'(h_f),   32'd1280);
    check("full_nf_v",    32'(v_f),   32'd2);
    check("full_fc",      32'(fc_f),  32'd1);

    goto(4848);
    check("checker_32_32", 32'(pix_m), 32'h000000);
    goto(4900);
    check("mid_fc_3",     32'(fc_m),  32'd3);
    rst_m = 1'b1;
    goto(4901);
    check("midrst_h",     32'(h_m),   32'd0);
    check("midrst_v",     32'(v_m),   32'd0);
    check("midrst_active", 32'(act_m), 32'd0);
    check("midrst_pixel", 32'(pix_m), 32'd0);
    check("midrst_fc",    32'(fc_m),  32'd0);
    check("midrst_hs",    32'(hs_m),  32'd1);
    rst_m = 1'b0;
    goto(4902);
    check("midrel_h",     32'(h_m),   32'd0);
    check("midrel_v",     32'(v_m),   32'd0);
    check("midrel_active", 32'(act_m), 32'd1);
    check("midrel_solid", 32'(pix_m), 32'h5A5A5A);
    goto(4903);
    check("midrel_h1",    32'(h_m),   32'd1);

    goto(8249);
    check("frame_end_h",  32'(h_f),   32'd1649);
    check("frame_end_v",  32'(v_f),   32'd4);
    goto(8250);
    check("frame_wrap_h", 32'(h_f),   32'd0);
    check("frame_wrap_v", 32'(v_f),   32'd0);
    goto(8409);
    check("bar_159",      32'(pix_f), 32'hFFFFFF);
    goto(8410);
    check("bar_160",      32'(pix_f), 32'hFFFF00);
    goto(9369);
    check("bar_1119",     32'(pix_f), 32'h0000FF);
    goto(9370);
    check("bar_1120",     32'(pix_f), 32'h000000);
    goto(9530);
    check("bar_1280",     32'(pix_f), 32'h000000);
    check("bar_1280_act", 32'(act_f), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
